// File: rtl/sonar_pkg.sv
// Shared state encoding, default timing constants and helpers for the
// three-sensor ultrasonic rangefinder sequencer.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    GAP,
    DONE
  } state_t;

  localparam int unsigned TRIG_CYCLES    = 500;
  localparam int unsigned CM_CYCLES      = 2941;
  localparam int unsigned TIMEOUT_CYCLES = 1_500_000;
  localparam int unsigned GAP_CYCLES     = 50_000;
  localparam int unsigned DIST_W         = 10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sonar_scheduler_contador_cm.sv
// Echo-width to centimetre converter shared by all three sensors: counts
// whole centimetres, rounds on the residue and flags over-long echoes.
module contador_cm #(
  parameter int unsigned CM_CYCLES      = sonar_pkg::CM_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = sonar_pkg::TIMEOUT_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        enable,
  output logic [sonar_pkg::DIST_W-1:0] cm_arred,
  output logic                        estouro
);
  import sonar_pkg::*;

  localparam int unsigned SUB_W = $clog2(CM_CYCLES + 1);
  localparam int unsigned WID_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DIST_W-1:0] CM_MAX    = '1;
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CM_CYCLES - 1);
  localparam logic [SUB_W-1:0]  SUB_HALF  = SUB_W'(CM_CYCLES / 2);
  localparam logic [WID_W-1:0]  WID_LIMIT = WID_W'(TIMEOUT_CYCLES);

  logic [SUB_W-1:0]  sub;
  logic [DIST_W-1:0] cm;
  logic [WID_W-1:0]  width;

  // The raw width counter is kept apart from cm because cm saturates
  // long before the timeout limit when CM_CYCLES is small.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub   <= '0;
      cm    <= '0;
      width <= '0;
    end else if (clear) begin
      sub   <= '0;
      cm    <= '0;
      width <= '0;
    end else if (enable) begin
      if (sub == SUB_LAST) begin
        sub <= '0;
        if (cm != CM_MAX) cm <= cm + 1'b1;
      end else begin
        sub <= sub + 1'b1;
      end
      if (!estouro) width <= width + 1'b1;
    end
  end

  assign estouro  = (width == WID_LIMIT);
  assign cm_arred = ((sub >= SUB_HALF) && (cm != CM_MAX)) ? cm + 1'b1 : cm;

endmodule

// File: rtl/sonar_scheduler.sv
// Fires three rangefinders strictly in sequence, times each echo with one
// shared converter and publishes rounded distances plus timeout flags.
module sonar_scheduler #(
  parameter int unsigned TRIG_CYCLES    = sonar_pkg::TRIG_CYCLES,
  parameter int unsigned CM_CYCLES      = sonar_pkg::CM_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = sonar_pkg::TIMEOUT_CYCLES,
  parameter int unsigned GAP_CYCLES     = sonar_pkg::GAP_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ligar,
  input  logic                         echo1,
  input  logic                         echo2,
  input  logic                         echo3,
  output logic                         trigger1,
  output logic                         trigger2,
  output logic                         trigger3,
  output logic [sonar_pkg::DIST_W-1:0] dist1,
  output logic [sonar_pkg::DIST_W-1:0] dist2,
  output logic [sonar_pkg::DIST_W-1:0] dist3,
  output logic [2:0]                   erro,
  output logic                         ocupado,
  output logic                         pronto
);
  import sonar_pkg::*;

  localparam int unsigned TMR_W = $clog2(max3(TRIG_CYCLES, TIMEOUT_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TMR_W-1:0] TRIG_LAST    = TMR_W'(TRIG_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST     = TMR_W'(GAP_CYCLES - 1);

  state_t            state, state_nx;
  logic [1:0]        sel, sel_nx;
  logic [TMR_W-1:0]  timer, timer_nx;
  logic [2:0]        echo_meta, echo_sync, echo_prev;
  logic              echo_act, echo_rise;
  logic              cnt_clear, cnt_enable;
  logic              fin_ok, fin_to;
  logic [DIST_W-1:0] cm_arred;
  logic              estouro;
  logic [DIST_W-1:0] dist_q [3];
  logic [2:0]        erro_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      echo_meta <= '0;
      echo_sync <= '0;
      echo_prev <= '0;
    end else begin
      echo_meta <= {echo3, echo2, echo1};
      echo_sync <= echo_meta;
      echo_prev <= echo_sync;
    end
  end

  always_comb begin
    case (sel)
      2'd0:    begin echo_act = echo_sync[0]; echo_rise = echo_sync[0] & ~echo_prev[0]; end
      2'd1:    begin echo_act = echo_sync[1]; echo_rise = echo_sync[1] & ~echo_prev[1]; end
      default: begin echo_act = echo_sync[2]; echo_rise = echo_sync[2] & ~echo_prev[2]; end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= '0;
      timer <= '0;
    end else begin
      state <= state_nx;
      sel   <= sel_nx;
      timer <= timer_nx;
    end
  end

  // The converter is held cleared while waiting and counts the rise cycle
  // itself, so its tick count equals the synchronized echo high time.
  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    timer_nx   = timer + 1'b1;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    fin_ok     = 1'b0;
    fin_to     = 1'b0;
    unique case (state)
      IDLE: begin
        timer_nx = '0;
        if (ligar) begin
          sel_nx   = '0;
          state_nx = TRIG;
        end
      end
      TRIG: begin
        if (timer == TRIG_LAST) begin
          timer_nx = '0;
          state_nx = WAIT_ECHO;
        end
      end
      WAIT_ECHO: begin
        cnt_clear  = ~echo_rise;
        cnt_enable = echo_rise;
        if (echo_rise) begin
          timer_nx = '0;
          state_nx = MEASURE;
        end else if (timer == TIMEOUT_LAST) begin
          timer_nx = '0;
          fin_to   = 1'b1;
          state_nx = GAP;
        end
      end
      MEASURE: begin
        timer_nx   = '0;
        cnt_clear  = 1'b0;
        cnt_enable = echo_act;
        if (!echo_act) begin
          fin_ok   = 1'b1;
          state_nx = GAP;
        end else if (estouro) begin
          fin_to   = 1'b1;
          state_nx = GAP;
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          timer_nx = '0;
          if (sel == 2'd2) begin
            state_nx = DONE;
          end else begin
            sel_nx   = sel + 2'd1;
            state_nx = TRIG;
          end
        end
      end
      DONE: begin
        timer_nx = '0;
        state_nx = IDLE;
      end
      default: begin
        timer_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  contador_cm #(
    .CM_CYCLES      (CM_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_contador_cm (
    .clock    (clock),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .cm_arred (cm_arred),
    .estouro  (estouro)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) dist_q[k] <= '0;
      erro_q <= '0;
    end else if (fin_ok || fin_to) begin
      for (int k = 0; k < 3; k++) begin
        if (sel == 2'(k)) begin
          dist_q[k] <= fin_ok ? cm_arred : '0;
          erro_q[k] <= fin_to;
        end
      end
    end
  end

  assign trigger1 = (state == TRIG) && (sel == 2'd0);
  assign trigger2 = (state == TRIG) && (sel == 2'd1);
  assign trigger3 = (state == TRIG) && (sel == 2'd2);
  assign ocupado  = (state != IDLE);
  assign pronto   = (state == DONE);
  assign dist1    = dist_q[0];
  assign dist2    = dist_q[1];
  assign dist3    = dist_q[2];
  assign erro     = erro_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler: echo pulses of chosen or random
// width, checked against an arithmetic distance/timeout model.
module tb_sonar_scheduler;

  localparam int TRIG  = 5;
  localparam int CM    = 6;
  localparam int TMO   = 6400;
  localparam int GAP   = 10;
  localparam int BOUND = 20000;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ligar = 1'b0;
  logic       echo1 = 1'b0, echo2 = 1'b0, echo3 = 1'b0;
  logic       trigger1, trigger2, trigger3;
  logic [9:0] dist1, dist2, dist3;
  logic [2:0] erro;
  logic       ocupado, pronto;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [9:0] exp_dist [3];
  logic [2:0] exp_erro;

  always #5 clock = ~clock;

  sonar_scheduler #(
    .TRIG_CYCLES    (TRIG),
    .CM_CYCLES      (CM),
    .TIMEOUT_CYCLES (TMO),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ligar    (ligar),
    .echo1    (echo1),
    .echo2    (echo2),
    .echo3    (echo3),
    .trigger1 (trigger1),
    .trigger2 (trigger2),
    .trigger3 (trigger3),
    .dist1    (dist1),
    .dist2    (dist2),
    .dist3    (dist3),
    .erro     (erro),
    .ocupado  (ocupado),
    .pronto   (pronto)
  );

  function automatic logic [2:0] trig_vec();
    return {trigger3, trigger2, trigger1};
  endfunction

  // Nearest-centimetre distance of an echo lasting w clocks, saturating.
  function automatic int model_dist(input int w);
    int r;
    r = w / CM + (((w % CM) >= CM / 2) ? 1 : 0);
    return (r > 1023) ? 1023 : r;
  endfunction

  task automatic set_echo(input int k, input logic v);
    case (k)
      0:       echo1 = v;
      1:       echo2 = v;
      default: echo3 = v;
    endcase
  endtask

  task automatic start_round();
    @(negedge clock);
    n_cmp++;
    if ({ocupado, pronto} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL start_idle: ocupado,pronto=%b expected 00", {ocupado, pronto});
    end
    ligar = 1'b1;
    @(negedge clock);
    ligar = 1'b0;
    n_cmp++;
    if ({trig_vec(), ocupado} !== 4'b0011) begin
      n_fail++;
      $display("[TB] FAIL start_latency: trig3..1,ocupado=%b expected 0011", {trig_vec(), ocupado});
    end
  endtask

  // mode 0: echo pulse of w clocks, 1: no echo, 2: echo held high before
  // the trigger, 3: start an echo and leave it high (for the reset test).
  task automatic run_sensor(input int k, input int mode, input int w, input int dly,
                            input bit noise);
    logic [2:0] tv;
    int cyc, hi;
    bit order_bad, overlap;
    cyc = 0; hi = 0; order_bad = 1'b0; overlap = 1'b0;
    if (mode == 2) set_echo(k, 1'b1);
    tv = trig_vec();
    while (!tv[k] && cyc < BOUND) begin
      if (tv != 3'b000) order_bad = 1'b1;
      @(negedge clock);
      cyc++;
      tv = trig_vec();
    end
    n_cmp++;
    if (cyc >= BOUND || order_bad) begin
      n_fail++;
      $display("[TB] FAIL trig%0d_order: waited %0d cycles, foreign trigger=%0d, expected trigger%0d alone",
               k + 1, cyc, order_bad, k + 1);
      return;
    end
    n_cmp++;
    if ({dist3, dist2, dist1, erro} !== {exp_dist[2], exp_dist[1], exp_dist[0], exp_erro}) begin
      n_fail++;
      $display("[TB] FAIL snapshot_at_trig%0d: dist3..1=%0d,%0d,%0d erro=%b expected %0d,%0d,%0d erro=%b",
               k + 1, dist3, dist2, dist1, erro, exp_dist[2], exp_dist[1], exp_dist[0], exp_erro);
    end
    while (tv[k] && hi < BOUND) begin
      if (tv != (3'b001 << k)) overlap = 1'b1;
      hi++;
      @(negedge clock);
      tv = trig_vec();
    end
    n_cmp++;
    if (hi != TRIG || overlap) begin
      n_fail++;
      $display("[TB] FAIL trig%0d_width: high %0d cycles overlap=%0d expected %0d cycles overlap=0",
               k + 1, hi, overlap, TRIG);
    end
    case (mode)
      0: begin
        repeat (dly) @(negedge clock);
        set_echo(k, 1'b1);
        if (noise) begin
          set_echo((k + 1) % 3, 1'b1);
          set_echo((k + 2) % 3, 1'b1);
        end
        for (int i = 0; i < w; i++) begin
          @(negedge clock);
          if (noise && i == w / 2) begin
            set_echo((k + 1) % 3, 1'b0);
            set_echo((k + 2) % 3, 1'b0);
          end
        end
        set_echo(k, 1'b0);
        if (w <= TMO) begin
          exp_dist[k] = 10'(model_dist(w));
          exp_erro[k] = 1'b0;
        end else begin
          exp_dist[k] = '0;
          exp_erro[k] = 1'b1;
        end
      end
      1: begin
        exp_dist[k] = '0;
        exp_erro[k] = 1'b1;
      end
      2: begin
        repeat (TMO + 5) @(negedge clock);
        set_echo(k, 1'b0);
        exp_dist[k] = '0;
        exp_erro[k] = 1'b1;
      end
      default: begin
        repeat (dly) @(negedge clock);
        set_echo(k, 1'b1);
        repeat (20) @(negedge clock);
      end
    endcase
  endtask

  task automatic run_round(input int mode[3], input int w[3], input int dly[3], input bit noise);
    int cyc;
    start_round();
    for (int k = 0; k < 3; k++) run_sensor(k, mode[k], w[k], dly[k], noise);
    cyc = 0;
    while (pronto !== 1'b1 && cyc < BOUND) begin
      @(negedge clock);
      cyc++;
    end
    n_cmp++;
    if (cyc >= BOUND) begin
      n_fail++;
      $display("[TB] FAIL pronto_wait: no pronto within %0d cycles", BOUND);
    end else if (mode[2] == 0 && w[2] <= TMO) begin
      // two synchronizer clocks, one result-load clock, then the gap
      n_cmp++;
      if (cyc != GAP + 3) begin
        n_fail++;
        $display("[TB] FAIL pronto_latency: %0d cycles after last echo fall, expected %0d", cyc, GAP + 3);
      end
    end
    n_cmp++;
    if ({dist3, dist2, dist1, erro} !== {exp_dist[2], exp_dist[1], exp_dist[0], exp_erro}) begin
      n_fail++;
      $display("[TB] FAIL round_results: dist3..1=%0d,%0d,%0d erro=%b expected %0d,%0d,%0d erro=%b",
               dist3, dist2, dist1, erro, exp_dist[2], exp_dist[1], exp_dist[0], exp_erro);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({trig_vec(), ocupado, pronto, erro} !== 8'h00 || {dist1, dist2, dist3} !== 30'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_held: trig=%b ocupado=%b pronto=%b erro=%b dist=%0d,%0d,%0d expected all 0",
               trig_vec(), ocupado, pronto, erro, dist1, dist2, dist3);
    end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({trig_vec(), ocupado, pronto, erro} !== 8'h00 || {dist1, dist2, dist3} !== 30'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: trig=%b ocupado=%b pronto=%b erro=%b expected all 0",
               trig_vec(), ocupado, pronto, erro);
    end
  endtask

  task automatic test_nominal();
    int m[3], w[3], d[3];
    m = '{0, 0, 0}; w = '{600, 600, 600}; d = '{0, 3, 7};
    run_round(m, w, d, 1'b0);
  endtask

  task automatic test_rounding();
    int m[3], w[3], d[3];
    m = '{0, 0, 0}; w = '{602, 446, 447}; d = '{2, 0, 5};
    run_round(m, w, d, 1'b0);
  endtask

  task automatic test_no_echo();
    int m[3], w[3], d[3];
    m = '{0, 1, 0}; w = '{300, 0, 123}; d = '{1, 0, 4};
    run_round(m, w, d, 1'b0);
  endtask

  task automatic test_echo_held();
    int m[3], w[3], d[3];
    m = '{0, 2, 0}; w = '{250, 0, 90}; d = '{0, 0, 2};
    run_round(m, w, d, 1'b0);
  endtask

  task automatic test_saturation();
    int m[3], w[3], d[3];
    m = '{0, 0, 0}; w = '{6300, TMO + 5, 6141}; d = '{0, 1, 2};
    run_round(m, w, d, 1'b0);
  endtask

  task automatic test_ligar_ignored();
    int m[3], w[3], d[3];
    bit bad;
    m = '{0, 0, 0}; w = '{210, 155, 333}; d = '{4, 0, 9};
    bad = 1'b0;
    fork
      run_round(m, w, d, 1'b0);
      begin
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3 * BOUND; i++) begin
          @(negedge clock);
          if (pronto) break;
          ligar = 1'($urandom_range(0, 1));
        end
        ligar = 1'b0;
      end
    join
    repeat (20) begin
      @(negedge clock);
      if (pronto || ocupado) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("[TB] FAIL single_pronto: pronto/ocupado seen after round end, expected both 0");
    end
  endtask

  task automatic test_random();
    int m[3], w[3], d[3];
    for (int r = 0; r < 3; r++) begin
      m = '{0, 0, 0};
      for (int k = 0; k < 3; k++) begin
        w[k] = int'($urandom_range(1, 900));
        d[k] = int'($urandom_range(0, 12));
      end
      run_round(m, w, d, r[0]);
    end
  endtask

  task automatic test_mid_reset();
    int m[3], w[3], d[3];
    start_round();
    run_sensor(0, 0, 300, 3, 1'b0);
    run_sensor(1, 3, 0, 2, 1'b0);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({trig_vec(), ocupado, pronto, erro} !== 8'h00 || {dist1, dist2, dist3} !== 30'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: trig=%b ocupado=%b pronto=%b erro=%b dist=%0d,%0d,%0d expected all 0",
               trig_vec(), ocupado, pronto, erro, dist1, dist2, dist3);
    end
    for (int k = 0; k < 3; k++) exp_dist[k] = '0;
    exp_erro = '0;
    set_echo(1, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    m = '{0, 0, 0}; w = '{120, 480, 61}; d = '{0, 6, 1};
    run_round(m, w, d, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) exp_dist[k] = '0;
    exp_erro = '0;
    test_reset();
    test_nominal();
    test_rounding();
    test_no_echo();
    test_echo_held();
    test_saturation();
    test_ligar_ignored();
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
